seq_pc: RTL and testbench
=========================

# seq_pc

Parametrised program sequencer for the basic processor. Holds the program counter and supports sequential increment, absolute jumps, condition-selectable relative branches, and call/return through an internal return-address stack. It adds run/idle/done/error status so the testbench and top level can detect program completion and stack misuse. It sits between the decoder/ALU flags and the instruction ROM address port.

## Interface
Parameters:
- PC_W, 10, PC and Target width; address space 2**PC_W
- OFF_W, 8, signed relative-offset width (OFF_W <= PC_W)
- RAS_DEPTH, 4, return-address stack entries (>= 1)
- START_ADDR, 0, PC value loaded by Reset and Start
- END_ADDR, 63, PC value that ends the program

Ports:
- CLK  in  1  clock; all state changes on posedge
- Reset  in  1  asynchronous, active-high; one clock, reset async active-high
- Start  in  1  synchronous (re)start
- Stall  in  1  1: freeze all state this cycle
- Op  in  3  seq_pc_pkg::op_t: OP_INC, OP_JMP, OP_BR, OP_CALL, OP_RET
- Cond  in  2  seq_pc_pkg::cond_t for OP_BR: C_ALWAYS, C_ZERO, C_NZERO, C_NEG
- Zero  in  1  ALU zero flag
- Neg  in  1  ALU negative flag
- Target  in  PC_W  absolute target for OP_JMP / OP_CALL
- Offset  in  OFF_W  signed offset for OP_BR
- PC  out  PC_W  current program counter
- Running  out  1  state == RUN
- Done  out  1  state == DONE
- Err  out  1  state == ERR
- Depth  out  $clog2(RAS_DEPTH+1)  occupied stack entries

## Operation
- States: IDLE, RUN, DONE, ERR.
- Reset (async): state IDLE, PC = START_ADDR, Depth = 0, stack contents don't-care. Running/Done/Err = 0.
- Start = 1 in any state (highest synchronous priority, overrides Stall): state RUN, PC = START_ADDR, Depth = 0.
- IDLE, DONE, ERR: hold everything until Start.
- RUN, priority after Start:
  - Stall = 1: hold PC, Depth, and state; Op is ignored.
  - PC == END_ADDR: state DONE, PC holds at END_ADDR; Op is ignored.
  - OP_INC: PC <= PC + 1.
  - OP_JMP: PC <= Target.
  - OP_BR: if the condition holds, PC <= PC + sext(Offset); else PC + 1. ALWAYS = 1, ZERO = Zero, NZERO = !Zero, NEG = Neg.
  - OP_CALL: if Depth < RAS_DEPTH, push PC + 1 and set PC <= Target. If full: state ERR, PC and stack hold.
  - OP_RET: if Depth > 0, PC <= popped top. If empty: state ERR, PC holds.
  - Undefined Op encodings (5-7) behave as OP_INC.
- Arithmetic is modulo 2**PC_W. Increment at 2**PC_W-1 wraps to 0. Relative branches wrap both ways. Offset is sign-extended to PC_W.
- The pushed return address is also modulo 2**PC_W.

## Timing
- Registered outputs only. PC, status, and Depth update on the posedge following the inputs that cause the change.
- A taken branch, jump, call, or return changes PC in one cycle; there is no bubble.
- Op/flags are sampled together with the current PC. The decoder must present Op for the instruction at PC in the same cycle.
- A call and a return on consecutive cycles is legal. The return sees the entry pushed the previous cycle.
- Reset asserted mid-run forces IDLE immediately (async). After deassertion, the sequencer waits for Start.

## Structure
- Package seq_pc_pkg holds op_t, cond_t, the state_t enum, and encodings (OP_INC=0, OP_JMP=1, OP_BR=2, OP_CALL=3, OP_RET=4; C_ALWAYS=0, C_ZERO=1, C_NZERO=2, C_NEG=3).
- Sub-module ras_stack (parameters WIDTH, DEPTH) provides a LIFO with push, pop, top, full, empty, and count. It shares CLK and Reset, with async reset of the count only.
- The top level contains the FSM, next-PC mux, and condition evaluation.

## Test plan
- Reset then Start, OP_INC for 63 cycles -> PC steps 0..63. On the next cycle Done = 1 and PC stays 63 while Op keeps toggling.
- PC = 10, OP_BR, Cond = C_ZERO, Offset = -4: with Zero = 1 -> PC = 6; with Zero = 0 -> PC = 11. With PC = 2 and Offset = -4 (PC_W = 10) -> PC = 1022.
- PC = 5, OP_CALL with Target = 40 -> PC = 40, Depth = 1. Then OP_RET -> PC = 6, Depth = 0.
- Five nested CALLs with RAS_DEPTH = 4 -> the fifth sets Err = 1 and PC holds. Start -> Err = 0, PC = 0, Depth = 0.
- OP_RET with Depth = 0 -> Err = 1. Stall = 1 during an OP_JMP to 30 -> PC unchanged. After Stall drops -> PC = 30.
- Reset pulse between clock edges while PC = 20 -> PC = START_ADDR and Running = 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/seq_pc_pkg.sv
// seq_pc_pkg: shared types for the program sequencer.
//   op_t    - sequencer operation selected by the decoder
//   cond_t  - branch condition selector for OP_BR
//   state_t - sequencer run state
//   cond_met() - evaluates a branch condition against the ALU flags
package seq_pc_pkg;

   typedef enum logic [2:0] {
      OP_INC  = 3'd0,
      OP_JMP  = 3'd1,
      OP_BR   = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4
   } op_t;

   typedef enum logic [1:0] {
      C_ALWAYS = 2'd0,
      C_ZERO   = 2'd1,
      C_NZERO  = 2'd2,
      C_NEG    = 2'd3
   } cond_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   function automatic logic cond_met(input cond_t c, input logic zero, input logic neg);
      logic r;
      case (c)
         C_ALWAYS: r = 1'b1;
         C_ZERO:   r = zero;
         C_NZERO:  r = ~zero;
         default:  r = neg;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_pc_ras_stack.sv
// ras_stack: return-address LIFO for the sequencer.
//   CLK, Reset  - clock and async active-high reset (clears the count only)
//   i_clr       - synchronous flush (count to zero)
//   i_push      - push i_data (ignored when full)
//   i_pop       - discard top entry (ignored when empty)
//   o_top       - current top entry (undefined when empty)
//   o_full, o_empty, o_count - occupancy status
module ras_stack #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       Reset,
   input  logic                       i_clr,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_top,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_rd_idx;
   logic             w_do_push;
   logic             w_do_pop;

   // Count is the index of the next free slot; top lives one below it.
   assign w_wr_idx  = AW'(r_count);
   assign w_rd_idx  = AW'(r_count - CW'(1));
   assign w_do_push = i_push & ~o_full & ~i_clr;
   assign w_do_pop  = i_pop & ~o_empty & ~i_clr & ~i_push;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (w_do_push) begin
         r_count <= r_count + CW'(1);
      end else if (w_do_pop) begin
         r_count <= r_count - CW'(1);
      end
   end

   // Storage has no reset: stale entries are unreachable once count is cleared.
   always_ff @(posedge CLK) begin
      if (w_do_push) begin
         r_mem[w_wr_idx] <= i_data;
      end
   end

   assign o_top   = r_mem[w_rd_idx];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/seq_pc.sv
// seq_pc: program sequencer holding the PC for the basic processor.
//   CLK, Reset  - clock, async active-high reset (to IDLE, PC = START_ADDR)
//   Start       - synchronous (re)start, overrides everything but Reset
//   Stall       - freeze all state this cycle
//   Op, Cond    - sequencer operation and branch condition (seq_pc_pkg)
//   Zero, Neg   - ALU flags for conditional branches
//   Target      - absolute target for OP_JMP / OP_CALL
//   Offset      - signed relative offset for OP_BR
//   PC          - current program counter (ROM address)
//   Running, Done, Err - state decode
//   Depth       - occupied return-stack entries
module seq_pc
   import seq_pc_pkg::*;
#(
   parameter int PC_W       = 10,
   parameter int OFF_W      = 8,
   parameter int RAS_DEPTH  = 4,
   parameter int START_ADDR = 0,
   parameter int END_ADDR   = 63
) (
   input  logic                           CLK,
   input  logic                           Reset,
   input  logic                           Start,
   input  logic                           Stall,
   input  logic [2:0]                     Op,
   input  logic [1:0]                     Cond,
   input  logic                           Zero,
   input  logic                           Neg,
   input  logic [PC_W-1:0]                Target,
   input  logic signed [OFF_W-1:0]        Offset,
   output logic [PC_W-1:0]                PC,
   output logic                           Running,
   output logic                           Done,
   output logic                           Err,
   output logic [$clog2(RAS_DEPTH+1)-1:0] Depth
);

   localparam logic [PC_W-1:0] C_START = PC_W'(START_ADDR);
   localparam logic [PC_W-1:0] C_END   = PC_W'(END_ADDR);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  w_pc_nxt;
   logic [PC_W-1:0]  w_pc_inc;
   logic [PC_W-1:0]  w_pc_rel;
   logic signed [PC_W-1:0] w_off_ext;
   logic             w_push;
   logic             w_pop;
   logic             w_clr;
   logic [PC_W-1:0]  w_top;
   logic             w_full;
   logic             w_empty;

   // Signed size cast sign-extends; the add then wraps modulo 2**PC_W.
   assign w_off_ext = PC_W'(Offset);
   assign w_pc_inc  = r_pc + PC_W'(1);
   assign w_pc_rel  = r_pc + w_off_ext;

   ras_stack #(
      .WIDTH (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .CLK     (CLK),
      .Reset   (Reset),
      .i_clr   (w_clr),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_pc_inc),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (Depth)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_pc    <= C_START;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_clr       = 1'b0;
      if (Start) begin
         w_state_nxt = ST_RUN;
         w_pc_nxt    = C_START;
         w_clr       = 1'b1;
      end else if (r_state == ST_RUN && !Stall) begin
         // Reaching END_ADDR finishes the program regardless of Op.
         if (r_pc == C_END) begin
            w_state_nxt = ST_DONE;
         end else begin
            case (Op)
               OP_JMP: w_pc_nxt = Target;
               OP_BR:  w_pc_nxt = cond_met(cond_t'(Cond), Zero, Neg) ? w_pc_rel : w_pc_inc;
               OP_CALL: begin
                  if (w_full) begin
                     w_state_nxt = ST_ERR;
                  end else begin
                     w_push   = 1'b1;
                     w_pc_nxt = Target;
                  end
               end
               OP_RET: begin
                  if (w_empty) begin
                     w_state_nxt = ST_ERR;
                  end else begin
                     w_pop    = 1'b1;
                     w_pc_nxt = w_top;
                  end
               end
               default: w_pc_nxt = w_pc_inc;
            endcase
         end
      end
   end

   assign PC      = r_pc;
   assign Running = (r_state == ST_RUN);
   assign Done    = (r_state == ST_DONE);
   assign Err     = (r_state == ST_ERR);

endmodule

// File: tb/tb_seq_pc.sv
module tb_seq_pc;

   localparam int PC_W  = 10;
   localparam int MOD   = 1 << PC_W;
   localparam int START = 0;
   localparam int ENDA  = 63;
   localparam int RASD  = 4;

   logic              CLK = 1'b0;
   logic              Reset;
   logic              Start;
   logic              Stall;
   logic [2:0]        Op;
   logic [1:0]        Cond;
   logic              Zero;
   logic              Neg;
   logic [PC_W-1:0]   Target;
   logic signed [7:0] Offset;
   logic [PC_W-1:0]   PC;
   logic              Running;
   logic              Done;
   logic              Err;
   logic [2:0]        Depth;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: state 0 idle, 1 run, 2 done, 3 err
   int m_pc;
   int m_state;
   int m_stk[$];

   seq_pc #(
      .PC_W(PC_W), .OFF_W(8), .RAS_DEPTH(RASD), .START_ADDR(START), .END_ADDR(ENDA)
   ) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Stall(Stall), .Op(Op), .Cond(Cond),
      .Zero(Zero), .Neg(Neg), .Target(Target), .Offset(Offset), .PC(PC),
      .Running(Running), .Done(Done), .Err(Err), .Depth(Depth)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % MOD) + MOD) % MOD;
   endfunction

   task automatic m_reset();
      m_pc = START;
      m_state = 0;
      m_stk.delete();
   endtask

   task automatic m_step();
      int  off;
      bit  taken;
      off = Offset;
      if (Start) begin
         m_state = 1;
         m_pc = START;
         m_stk.delete();
      end else if (m_state == 1 && !Stall) begin
         if (m_pc == ENDA) begin
            m_state = 2;
         end else begin
            case (Op)
               3'd1: m_pc = Target;
               3'd2: begin
                  case (Cond)
                     2'd0: taken = 1;
                     2'd1: taken = Zero;
                     2'd2: taken = !Zero;
                     default: taken = Neg;
                  endcase
                  m_pc = taken ? wrap(m_pc + off) : wrap(m_pc + 1);
               end
               3'd3: begin
                  if (m_stk.size() < RASD) begin
                     m_stk.push_back(wrap(m_pc + 1));
                     m_pc = Target;
                  end else m_state = 3;
               end
               3'd4: begin
                  if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                  else m_state = 3;
               end
               default: m_pc = wrap(m_pc + 1);
            endcase
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},    int'(PC),      m_pc);
      check({tag, ".run"},   int'(Running), int'(m_state == 1));
      check({tag, ".done"},  int'(Done),    int'(m_state == 2));
      check({tag, ".err"},   int'(Err),     int'(m_state == 3));
      check({tag, ".depth"}, int'(Depth),   m_stk.size());
   endtask

   task automatic set(input logic [2:0] o, input int tgt, input int off,
                      input logic [1:0] c, input logic z, input logic n);
      Op = o; Target = PC_W'(tgt); Offset = 8'(off); Cond = c; Zero = z; Neg = n;
      Start = 1'b0; Stall = 1'b0;
   endtask

   // One clock: model and DUT both advance on the edge, compare 1 time unit later.
   task automatic cyc(input string tag);
      @(posedge CLK);
      m_step();
      #1;
      check_all(tag);
   endtask

   task automatic do_start();
      set(3'd0, 0, 0, 2'd0, 1'b0, 1'b0);
      Start = 1'b1;
      cyc("start");
      Start = 1'b0;
   endtask

   initial begin
      Reset = 1'b1;
      set(3'd0, 0, 0, 2'd0, 1'b0, 1'b0);
      m_reset();
      #1;
      check_all("reset");
      #11;
      Reset = 1'b0;
      cyc("idle_hold");
      check("idle_pc", int'(PC), START);

      // Sequential run to END_ADDR then DONE with Op toggling
      do_start();
      for (int i = 0; i < 63; i++) cyc("inc");
      check("inc_pc63", int'(PC), 63);
      for (int i = 0; i < 4; i++) begin
         set((i % 2) ? 3'd1 : 3'd0, 5, 0, 2'd0, 1'b0, 1'b0);
         cyc("end_hold");
      end
      check("done_flag", int'(Done), 1);
      check("done_pc", int'(PC), 63);

      // Conditional branches
      do_start();
      set(3'd1, 10, 0, 2'd0, 1'b0, 1'b0); cyc("jmp10");
      set(3'd2, 0, -4, 2'd1, 1'b1, 1'b0); cyc("br_z_taken");
      check("br_z_taken_pc", int'(PC), 6);
      set(3'd1, 10, 0, 2'd0, 1'b0, 1'b0); cyc("jmp10b");
      set(3'd2, 0, -4, 2'd1, 1'b0, 1'b0); cyc("br_z_not");
      check("br_z_not_pc", int'(PC), 11);
      set(3'd1, 2, 0, 2'd0, 1'b0, 1'b0); cyc("jmp2");
      set(3'd2, 0, -4, 2'd0, 1'b0, 1'b0); cyc("br_wrap");
      check("br_wrap_pc", int'(PC), 1022);
      set(3'd1, 1023, 0, 2'd0, 1'b0, 1'b0); cyc("jmp1023");
      set(3'd0, 0, 0, 2'd0, 1'b0, 1'b0); cyc("inc_wrap");
      check("inc_wrap_pc", int'(PC), 0);
      set(3'd2, 0, 7, 2'd2, 1'b1, 1'b1); cyc("br_nz_not");
      set(3'd2, 0, 7, 2'd3, 1'b1, 1'b1); cyc("br_neg_taken");

      // Call / return
      set(3'd1, 5, 0, 2'd0, 1'b0, 1'b0); cyc("jmp5");
      set(3'd3, 40, 0, 2'd0, 1'b0, 1'b0); cyc("call40");
      check("call_pc", int'(PC), 40);
      check("call_depth", int'(Depth), 1);
      set(3'd4, 0, 0, 2'd0, 1'b0, 1'b0); cyc("ret");
      check("ret_pc", int'(PC), 6);
      check("ret_depth", int'(Depth), 0);

      // Stack overflow
      do_start();
      for (int i = 0; i < 5; i++) begin
         set(3'd3, 100 + 10 * i, 0, 2'd0, 1'b0, 1'b0);
         cyc("nest_call");
      end
      check("ovf_err", int'(Err), 1);
      check("ovf_pc", int'(PC), 130);
      do_start();
      check("restart_err", int'(Err), 0);
      check("restart_depth", int'(Depth), 0);

      // Stack underflow, then stall
      set(3'd4, 0, 0, 2'd0, 1'b0, 1'b0); cyc("ret_empty");
      check("unf_err", int'(Err), 1);
      do_start();
      set(3'd1, 30, 0, 2'd0, 1'b0, 1'b0);
      Stall = 1'b1;
      cyc("stall1");
      cyc("stall2");
      check("stall_pc", int'(PC), 0);
      Stall = 1'b0;
      cyc("unstall");
      check("unstall_pc", int'(PC), 30);

      // Async reset between edges
      set(3'd1, 20, 0, 2'd0, 1'b0, 1'b0); cyc("jmp20");
      set(3'd0, 0, 0, 2'd0, 1'b0, 1'b0);
      #2;
      Reset = 1'b1;
      #1;
      m_reset();
      check("async_rst_pc", int'(PC), START);
      check("async_rst_run", int'(Running), 0);
      check_all("async_rst");
      #1;
      Reset = 1'b0;
      cyc("post_rst_idle");

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int tgt;
         tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(50, 70)) : int'($urandom_range(0, MOD - 1));
         set(3'($urandom_range(0, 7)), tgt, int'($urandom_range(0, 255)) - 128,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         Stall = ($urandom_range(0, 7) == 0);
         Start = ($urandom_range(0, 59) == 0) || (m_state != 1 && $urandom_range(0, 3) == 0);
         cyc("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
